render_cfg_regs: RTL and testbench

RENDER_CFG_REGS -- requirements
Module: render_cfg_regs

---
 rtl/render_cfg_regs.sv | 191 +++++++++++++++++++
 tb/tb_render_cfg_regs.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/render_cfg_regs.sv
// Render configuration register block: Avalon-MM slave with shadow/active register banks,
// a start/busy/done handshake to the render pipeline, sticky status bits and a frame counter.
module render_cfg_regs #(
  parameter int DATA_W      = 32,
  parameter int NUM_MAT     = 2,
  parameter int LIGHT_WORDS = 3,
  parameter int BASE_W      = 26
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic [15:0]                   address,
  input  logic                          write,
  input  logic                          read,
  input  logic [DATA_W-1:0]             writedata,
  output logic [DATA_W-1:0]             readdata,
  output logic                          readdatavalid,
  output logic [NUM_MAT*16*DATA_W-1:0]  mat,
  output logic [LIGHT_WORDS*DATA_W-1:0] lighting,
  output logic [BASE_W-1:0]             frame_buffer_base,
  output logic [BASE_W-1:0]             vertex_buffer_base,
  output logic                          render_start,
  output logic                          busy,
  input  logic                          render_done
);

  localparam int                 MAT_WORDS = NUM_MAT * 16;
  localparam logic [BASE_W-1:0]  VB_RST    = BASE_W'(32'h0030_0000);
  localparam logic [7:0]         LIGHT_PG  = 8'(NUM_MAT + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ARM  = 2'd1,
    S_BUSY = 2'd2
  } state_t;

  state_t r_state, w_state_nxt;

  logic [DATA_W-1:0] r_mat_sh   [MAT_WORDS];
  logic [DATA_W-1:0] r_light_sh [LIGHT_WORDS];
  logic [BASE_W-1:0] r_fb_sh, r_vb_sh;

  logic [NUM_MAT*16*DATA_W-1:0]  r_mat_act;
  logic [LIGHT_WORDS*DATA_W-1:0] r_light_act;
  logic [BASE_W-1:0]             r_fb_act, r_vb_act;

  logic [15:0]       r_frame_cnt;
  logic              r_done, r_err, r_render_start;
  logic [DATA_W-1:0] r_rdata;
  logic              r_rvalid;

  // Address decode: page = address[15:8], word = address[7:2]
  logic [7:0] w_page;
  logic [5:0] w_word;
  logic       w_sel_fb, w_sel_vb, w_sel_ctrl, w_sel_fcnt;
  logic       w_ctrl_wr, w_start_req, w_rd_accept;
  logic       w_commit, w_frame_done, w_err_set;
  logic       w_unused;

  assign w_page      = address[15:8];
  assign w_word      = address[7:2];
  assign w_unused    = ^address[1:0];
  assign w_sel_fb    = (w_page == 8'd0) && (w_word == 6'd0);
  assign w_sel_vb    = (w_page == 8'd0) && (w_word == 6'd1);
  assign w_sel_ctrl  = (w_page == 8'd0) && (w_word == 6'd2);
  assign w_sel_fcnt  = (w_page == 8'd0) && (w_word == 6'd3);
  assign w_ctrl_wr   = write && w_sel_ctrl;
  assign w_start_req = w_ctrl_wr && writedata[0];
  assign w_rd_accept = read && !write;

  // FSM next-state and per-cycle strobes
  always_comb begin
    // NOTE: every signal written here gets a default first so no path leaves it unassigned (no latch).
    w_state_nxt  = r_state;
    w_commit     = 1'b0;
    w_frame_done = 1'b0;
    w_err_set    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_start_req) w_state_nxt = S_ARM;
      end
      S_ARM: begin
        w_commit    = 1'b1;
        w_err_set   = w_start_req;
        w_state_nxt = S_BUSY;
      end
      S_BUSY: begin
        w_err_set = w_start_req;
        if (render_done) begin
          w_frame_done = 1'b1;
          w_state_nxt  = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state        <= S_IDLE;
      r_done         <= 1'b0;
      r_err          <= 1'b0;
      r_frame_cnt    <= 16'd0;
      r_render_start <= 1'b0;
    end else begin
      r_state        <= w_state_nxt;
      // Registered so the pulse coincides with the freshly committed active outputs
      r_render_start <= w_commit;
      if (w_frame_done)                     r_done <= 1'b1;
      else if (w_ctrl_wr && writedata[1])   r_done <= 1'b0;
      if (w_err_set)                        r_err  <= 1'b1;
      else if (w_ctrl_wr && writedata[2])   r_err  <= 1'b0;
      if (w_frame_done) r_frame_cnt <= r_frame_cnt + 16'd1;
    end
  end

  // Shadow bank: the only thing bus writes ever touch
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      // NOTE: these register arrays are small flop banks with a defined reset value, so they are reset like any other state.
      for (int i = 0; i < MAT_WORDS; i++)   r_mat_sh[i]   <= '0;
      for (int i = 0; i < LIGHT_WORDS; i++) r_light_sh[i] <= '0;
      r_fb_sh <= '0;
      r_vb_sh <= VB_RST;
    end else if (write) begin
      if (w_sel_fb) r_fb_sh <= writedata[BASE_W-1:0];
      if (w_sel_vb) r_vb_sh <= writedata[BASE_W-1:0];
      for (int m = 0; m < NUM_MAT; m++) begin
        for (int w = 0; w < 16; w++) begin
          if (w_page == 8'(m + 1) && w_word == 6'(w)) r_mat_sh[m*16 + w] <= writedata;
        end
      end
      for (int w = 0; w < LIGHT_WORDS; w++) begin
        if (w_page == LIGHT_PG && w_word == 6'(w)) r_light_sh[w] <= writedata;
      end
    end
  end

  // Active bank: changes only on the single commit cycle of a frame start
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_mat_act   <= '0;
      r_light_act <= '0;
      r_fb_act    <= '0;
      r_vb_act    <= VB_RST;
    end else if (w_commit) begin
      for (int i = 0; i < MAT_WORDS; i++)   r_mat_act[i*DATA_W +: DATA_W]   <= r_mat_sh[i];
      for (int i = 0; i < LIGHT_WORDS; i++) r_light_act[i*DATA_W +: DATA_W] <= r_light_sh[i];
      r_fb_act <= r_fb_sh;
      r_vb_act <= r_vb_sh;
    end
  end

  // Read mux; anything not decoded reads as zero
  logic [DATA_W-1:0] w_rdata;
  always_comb begin
    w_rdata = '0;
    if (w_sel_fb)   w_rdata = DATA_W'(r_fb_sh);
    if (w_sel_vb)   w_rdata = DATA_W'(r_vb_sh);
    if (w_sel_ctrl) w_rdata = DATA_W'({r_err, r_done, busy});
    if (w_sel_fcnt) w_rdata = DATA_W'(r_frame_cnt);
    for (int m = 0; m < NUM_MAT; m++) begin
      for (int w = 0; w < 16; w++) begin
        if (w_page == 8'(m + 1) && w_word == 6'(w)) w_rdata = r_mat_sh[m*16 + w];
      end
    end
    for (int w = 0; w < LIGHT_WORDS; w++) begin
      if (w_page == LIGHT_PG && w_word == 6'(w)) w_rdata = r_light_sh[w];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rdata  <= '0;
      r_rvalid <= 1'b0;
    end else begin
      r_rvalid <= w_rd_accept;
      if (w_rd_accept) r_rdata <= w_rdata;
    end
  end

  assign busy               = (r_state != S_IDLE);
  assign render_start       = r_render_start;
  assign mat                = r_mat_act;
  assign lighting           = r_light_act;
  assign frame_buffer_base  = r_fb_act;
  assign vertex_buffer_base = r_vb_act;
  assign readdata           = r_rdata;
  assign readdatavalid      = r_rvalid;

endmodule

// File: tb/tb_render_cfg_regs.sv
// Directed bench for render_cfg_regs: bus reads are scored through an expected-value queue
// drained by a readdatavalid monitor; handshake and active outputs are checked inline.
module tb_render_cfg_regs;

  localparam int DATA_W      = 32;
  localparam int NUM_MAT     = 2;
  localparam int LIGHT_WORDS = 3;
  localparam int BASE_W      = 26;

  logic                          clk;
  logic                          reset_n;
  logic [15:0]                   address;
  logic                          write;
  logic                          read;
  logic [DATA_W-1:0]             writedata;
  logic [DATA_W-1:0]             readdata;
  logic                          readdatavalid;
  logic [NUM_MAT*16*DATA_W-1:0]  mat;
  logic [LIGHT_WORDS*DATA_W-1:0] lighting;
  logic [BASE_W-1:0]             frame_buffer_base;
  logic [BASE_W-1:0]             vertex_buffer_base;
  logic                          render_start;
  logic                          busy;
  logic                          render_done;

  render_cfg_regs #(
    .DATA_W(DATA_W), .NUM_MAT(NUM_MAT), .LIGHT_WORDS(LIGHT_WORDS), .BASE_W(BASE_W)
  ) dut (
    .clk(clk), .reset_n(reset_n), .address(address), .write(write), .read(read),
    .writedata(writedata), .readdata(readdata), .readdatavalid(readdatavalid),
    .mat(mat), .lighting(lighting), .frame_buffer_base(frame_buffer_base),
    .vertex_buffer_base(vertex_buffer_base), .render_start(render_start),
    .busy(busy), .render_done(render_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] addr;
    logic [31:0] data;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  function automatic logic [31:0] mat_word(input int m, input int w);
    return mat[(m*16 + w)*DATA_W +: DATA_W];
  endfunction

  function automatic logic [31:0] light_word(input int w);
    return lighting[w*DATA_W +: DATA_W];
  endfunction

  // Scoreboard monitor: every readdatavalid consumes one expected entry
  always @(negedge clk) begin
    if (readdatavalid) begin
      if (exp_q.size() == 0) begin
        check("unexpected_readdatavalid", 64'd1, 64'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check($sformatf("read_0x%03h", e.addr), 64'(readdata), 64'(e.data));
      end
    end
  end

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic bus_write(input logic [15:0] a, input logic [31:0] d);
    address   = a;
    writedata = d;
    write     = 1'b1;
    @(negedge clk);
    write     = 1'b0;
  endtask

  task automatic bus_read(input logic [15:0] a, input logic [31:0] exp);
    exp_t e;
    e.addr = a;
    e.data = exp;
    exp_q.push_back(e);
    address = a;
    read    = 1'b1;
    @(negedge clk);
    read    = 1'b0;
  endtask

  // Start a frame and finish it on the first BUSY cycle
  task automatic run_frame();
    bus_write(16'h008, 32'h1);
    cyc();
    render_done = 1'b1;
    cyc();
    render_done = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    reset_n     = 1'b0;
    address     = '0;
    write       = 1'b0;
    read        = 1'b0;
    writedata   = '0;
    render_done = 1'b0;
    repeat (3) cyc();

    check("rst_busy",          64'(busy),               64'd0);
    check("rst_render_start",  64'(render_start),       64'd0);
    check("rst_rdvalid",       64'(readdatavalid),      64'd0);
    check("rst_readdata",      64'(readdata),           64'd0);
    check("rst_vb_base",       64'(vertex_buffer_base), 64'h30_0000);
    check("rst_fb_base",       64'(frame_buffer_base),  64'd0);
    check("rst_mat_zero",      64'(mat == '0),          64'd1);
    reset_n = 1'b1;
    cyc();

    // Reset readback of VB_BASE
    bus_read(16'h004, 32'h0030_0000);
    check("vb_base_active", 64'(vertex_buffer_base), 64'h30_0000);

    // Shadow write is invisible until a frame starts
    bus_write(16'h104, 32'h3F80_0000);
    check("mat1_before_start", 64'(mat_word(0, 1)), 64'd0);
    bus_write(16'h008, 32'h1);
    check("arm_busy",          64'(busy),           64'd1);
    check("arm_no_start",      64'(render_start),   64'd0);
    check("arm_mat1_old",      64'(mat_word(0, 1)), 64'd0);
    cyc();
    check("start_pulse",       64'(render_start),   64'd1);
    check("start_mat1",        64'(mat_word(0, 1)), 64'h3F80_0000);
    check("start_busy",        64'(busy),           64'd1);

    // Writes during BUSY reach the shadow only; a second start flags ERR
    bus_write(16'h104, 32'h4000_0000);
    check("start_pulse_gone",  64'(render_start),   64'd0);
    bus_write(16'h008, 32'h1);
    check("busy_mat1_hold",    64'(mat_word(0, 1)), 64'h3F80_0000);
    bus_read(16'h008, 32'h5);
    bus_read(16'h104, 32'h4000_0000);

    // Frame completion
    render_done = 1'b1;
    cyc();
    render_done = 1'b0;
    check("done_busy_clear", 64'(busy), 64'd0);
    bus_read(16'h008, 32'h6);
    bus_read(16'h00C, 32'h1);
    bus_write(16'h008, 32'h6);
    bus_read(16'h008, 32'h0);

    // Unmapped read, FRAME_CNT write ignored, out-of-range lighting word
    bus_read(16'h7F0, 32'h0);
    bus_write(16'h00C, 32'h55);
    bus_read(16'h00C, 32'h1);
    bus_write(16'h308, 32'h0000_ABCD);
    bus_read(16'h308, 32'h0000_ABCD);
    bus_read(16'h30C, 32'h0);
    bus_read(16'h140, 32'h0);

    // Simultaneous read and write: write lands, read dropped, readdata held
    address   = 16'h000;
    writedata = 32'h0000_0123;
    write     = 1'b1;
    read      = 1'b1;
    cyc();
    write = 1'b0;
    read  = 1'b0;
    check("rw_no_rdvalid",    64'(readdatavalid), 64'd0);
    check("rw_readdata_hold", 64'(readdata),      64'd0);
    bus_read(16'h000, 32'h0000_0123);
    cyc();
    check("readdata_hold_idle", 64'(readdata), 64'h123);

    // Frame 2: render_done during ARM is ignored
    bus_write(16'h008, 32'h1);
    render_done = 1'b1;
    cyc();
    render_done = 1'b0;
    check("f2_start_pulse", 64'(render_start),      64'd1);
    check("f2_busy",        64'(busy),              64'd1);
    check("f2_light2",      64'(light_word(2)),     64'h0000_ABCD);
    check("f2_fb_base",     64'(frame_buffer_base), 64'h123);
    check("f2_mat1",        64'(mat_word(0, 1)),    64'h4000_0000);
    cyc();
    check("f2_arm_done_ignored", 64'(busy), 64'd1);
    render_done = 1'b1;
    cyc();
    render_done = 1'b0;
    bus_read(16'h00C, 32'h2);
    bus_read(16'h008, 32'h2);

    // Frame 3: start request on the same cycle render_done arrives
    bus_write(16'h008, 32'h1);
    cyc();
    render_done = 1'b1;
    bus_write(16'h008, 32'h1);
    render_done = 1'b0;
    check("f3_idle", 64'(busy), 64'd0);
    bus_read(16'h008, 32'h6);
    bus_read(16'h00C, 32'h3);

    // Frame 4: ERR set beats ERR clear; DONE clear still applies
    bus_write(16'h008, 32'h4);
    bus_read(16'h008, 32'h2);
    bus_write(16'h008, 32'h1);
    cyc();
    bus_write(16'h008, 32'h7);
    bus_read(16'h008, 32'h5);
    render_done = 1'b1;
    cyc();
    render_done = 1'b0;
    bus_read(16'h00C, 32'h4);
    bus_read(16'h008, 32'h6);

    // FRAME_CNT wrap
    force dut.r_frame_cnt = 16'hFFFF;
    #1;
    release dut.r_frame_cnt;
    bus_read(16'h00C, 32'h0000_FFFF);
    run_frame();
    bus_read(16'h00C, 32'h0);

    // Reset during ARM aborts the frame
    bus_write(16'h000, 32'h0000_0456);
    cyc();
    bus_write(16'h008, 32'h1);
    reset_n = 1'b0;
    repeat (2) cyc();
    reset_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc();
      check($sformatf("abort_no_start_%0d", i), 64'(render_start), 64'd0);
    end
    check("abort_busy",     64'(busy),               64'd0);
    check("abort_fb_base",  64'(frame_buffer_base),  64'd0);
    check("abort_vb_base",  64'(vertex_buffer_base), 64'h30_0000);
    check("abort_mat_zero", 64'(mat == '0),          64'd1);
    bus_read(16'h00C, 32'h0);
    bus_read(16'h008, 32'h0);
    bus_read(16'h104, 32'h0);

    for (int i = 0; i < 10; i++) begin
      if (exp_q.size() == 0) break;
      cyc();
    end
    check("scoreboard_drained", 64'(exp_q.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
